// File: rtl/reg_file.sv
// reg_file: eight-entry operand register file with registered dual read, single write and ALU flag latch.
// Define REG_FILE_BYPASS_EN to forward a same-edge write to the read ports.
module reg_file #(
   parameter int NREGS = 8,
   parameter int WIDTH = 8,
   parameter int FLAGW = 4,
   localparam int SELW = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rd_en,
   input  logic [SELW-1:0]  ra_sel,
   input  logic [SELW-1:0]  rb_sel,
   output logic [WIDTH-1:0] ra_data,
   output logic [WIDTH-1:0] rb_data,
   output logic             rd_valid,
   input  logic             wr_en,
   input  logic [SELW-1:0]  wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             flags_en,
   input  logic [FLAGW-1:0] flags_in,
   output logic [FLAGW-1:0] flags_out
);
   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH-1:0] ra_val, rb_val;
   logic             wr_ok;
   assign wr_ok = wr_en && wr_sel != '0;
`ifdef REG_FILE_BYPASS_EN
   assign ra_val = (wr_ok && wr_sel == ra_sel) ? wr_data : regs[ra_sel];
   assign rb_val = (wr_ok && wr_sel == rb_sel) ? wr_data : regs[rb_sel];
`else
   assign ra_val = regs[ra_sel];
   assign rb_val = regs[rb_sel];
`endif
   // r0 is only ever loaded by reset, so it always reads zero
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         ra_data   <= '0;
         rb_data   <= '0;
         rd_valid  <= 1'b0;
         flags_out <= '0;
      end else begin
         if (wr_ok) regs[wr_sel] <= wr_data;
         if (rd_en) begin
            ra_data <= ra_val;
            rb_data <= rb_val;
         end
         rd_valid <= rd_en;
         if (flags_en) flags_out <= flags_in;
      end
   end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed vector table plus a fill/read-back sequence for reg_file.
module tb_reg_file;
`ifdef REG_FILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic       clk = 1'b0, rst = 1'b0, rd_en = 1'b0, wr_en = 1'b0, flags_en = 1'b0;
   logic [2:0] ra_sel = '0, rb_sel = '0, wr_sel = '0;
   logic [7:0] wr_data = '0, ra_data, rb_data;
   logic [3:0] flags_in = '0, flags_out;
   logic       rd_valid;
   int         nvec = 0, nbad = 0;

   reg_file dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .ra_sel(ra_sel), .rb_sel(rb_sel),
      .ra_data(ra_data), .rb_data(rb_data), .rd_valid(rd_valid),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .flags_en(flags_en), .flags_in(flags_in), .flags_out(flags_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, rd_en;
      logic [2:0] ra_sel, rb_sel;
      logic       wr_en;
      logic [2:0] wr_sel;
      logic [7:0] wr_data;
      logic       flags_en;
      logic [3:0] flags_in;
      logic [7:0] ea, eb;
      logic       ev;
      logic [3:0] ef;
   } vec_t;

   vec_t tbl [22];

   function automatic vec_t mk(logic r, logic re, logic [2:0] a, logic [2:0] b,
                               logic we, logic [2:0] ws, logic [7:0] wd,
                               logic fe, logic [3:0] fi,
                               logic [7:0] ea, logic [7:0] eb, logic ev, logic [3:0] ef);
      return '{r, re, a, b, we, ws, wd, fe, fi, ea, eb, ev, ef};
   endfunction

   task automatic chk(string name, int idx, logic [7:0] act, logic [7:0] exp);
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic apply(vec_t v, int idx);
      @(negedge clk);
      rst = v.rst; rd_en = v.rd_en; ra_sel = v.ra_sel; rb_sel = v.rb_sel;
      wr_en = v.wr_en; wr_sel = v.wr_sel; wr_data = v.wr_data;
      flags_en = v.flags_en; flags_in = v.flags_in;
      @(posedge clk);
      #1;
      nvec++;
      chk("ra_data", idx, ra_data, v.ea);
      chk("rb_data", idx, rb_data, v.eb);
      chk("rd_valid", idx, {7'd0, rd_valid}, {7'd0, v.ev});
      chk("flags_out", idx, {4'd0, flags_out}, {4'd0, v.ef});
   endtask

   initial begin
      //           rst re ra rb we ws wd     fe fi      ea                    eb                    ev ef
      tbl[0]  = mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00, 0, 4'h0);
      tbl[1]  = mk(0, 0, 0, 0, 1, 3, 8'hA5, 1, 4'hF, 8'h00, 8'h00, 0, 4'hF);
      tbl[2]  = mk(1, 0, 0, 0, 0, 0, 8'h00, 1, 4'h3, 8'h00, 8'h00, 0, 4'h0);
      tbl[3]  = mk(0, 1, 3, 3, 0, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00, 1, 4'h0);
      tbl[4]  = mk(0, 0, 0, 0, 1, 1, 8'h3C, 0, 4'h0, 8'h00, 8'h00, 0, 4'h0);
      tbl[5]  = mk(0, 0, 0, 0, 1, 2, 8'hC3, 0, 4'h0, 8'h00, 8'h00, 0, 4'h0);
      tbl[6]  = mk(0, 1, 1, 2, 0, 0, 8'h00, 0, 4'h0, 8'h3C, 8'hC3, 1, 4'h0);
      tbl[7]  = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 4'h0, 8'h3C, 8'hC3, 0, 4'h0);
      tbl[8]  = mk(0, 0, 0, 0, 1, 0, 8'hFF, 0, 4'h0, 8'h3C, 8'hC3, 0, 4'h0);
      tbl[9]  = mk(0, 1, 0, 0, 0, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00, 1, 4'h0);
      tbl[10] = mk(0, 0, 0, 0, 1, 5, 8'h11, 0, 4'h0, 8'h00, 8'h00, 0, 4'h0);
      tbl[11] = mk(0, 1, 5, 1, 1, 5, 8'h22, 0, 4'h0, BYP ? 8'h22 : 8'h11, 8'h3C, 1, 4'h0);
      tbl[12] = mk(0, 1, 5, 5, 0, 0, 8'h00, 0, 4'h0, 8'h22, 8'h22, 1, 4'h0);
      tbl[13] = mk(0, 0, 0, 0, 0, 0, 8'h00, 1, 4'hA, 8'h22, 8'h22, 0, 4'hA);
      tbl[14] = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 4'h5, 8'h22, 8'h22, 0, 4'hA);
      tbl[15] = mk(1, 0, 0, 0, 1, 4, 8'h77, 0, 4'h0, 8'h00, 8'h00, 0, 4'h0);
      tbl[16] = mk(0, 1, 4, 1, 0, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00, 1, 4'h0);
      tbl[17] = mk(0, 1, 0, 0, 1, 0, 8'h99, 0, 4'h0, 8'h00, 8'h00, 1, 4'h0);
      tbl[18] = mk(0, 1, 7, 6, 1, 7, 8'h5A, 0, 4'h0, BYP ? 8'h5A : 8'h00, 8'h00, 1, 4'h0);
      tbl[19] = mk(0, 1, 6, 7, 1, 6, 8'h81, 0, 4'h0, BYP ? 8'h81 : 8'h00, 8'h5A, 1, 4'h0);
      tbl[20] = mk(0, 1, 6, 7, 0, 0, 8'h00, 0, 4'h0, 8'h81, 8'h5A, 1, 4'h0);
      tbl[21] = mk(0, 0, 0, 0, 1, 6, 8'h00, 0, 4'h0, 8'h81, 8'h5A, 0, 4'h0);
      for (int i = 0; i < 22; i++) apply(tbl[i], i);
      // fill every register with i*0x11 (r0 write must be dropped), then read mirrored pairs
      for (int i = 0; i < 8; i++)
         apply(mk(0, 0, 0, 0, 1, 3'(i), 8'(i * 17), 0, 4'h0, 8'h81, 8'h5A, 0, 4'h0), 100 + i);
      for (int i = 0; i < 8; i++)
         apply(mk(0, 1, 3'(i), 3'(7 - i), 0, 0, 8'h00, 0, 4'h0,
                  8'(i * 17), 8'((7 - i) * 17), 1, 4'h0), 200 + i);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule
